// File: rtl/spi_pwm_cmd_receiver_if.sv
// SPI pin bundle plus the PWM-driver write port of spi_pwm_cmd_receiver.
// master = SPI host / PWM driver side, slave = the receiver.
interface spi_pwm_cmd_receiver_if;
    logic       spi_sclk;
    logic       spi_cs_n;
    logic       spi_mosi;
    logic       spi_miso;
    logic       set;
    logic [2:0] addr;
    logic [2:0] val;
    logic       frame_err;

    modport master (
        output spi_sclk, spi_cs_n, spi_mosi,
        input  spi_miso, set, addr, val, frame_err
    );

    modport slave (
        input  spi_sclk, spi_cs_n, spi_mosi,
        output spi_miso, set, addr, val, frame_err
    );
endinterface

// File: rtl/spi_pwm_cmd_receiver.sv
// Oversampling SPI mode-0 slave that turns 8-bit frames into PWM level writes and echoes frames back.
// PARITY_CHECK_EN: enables frame parity checking and a 4-bit error counter on readback.
module spi_pwm_cmd_receiver #(
    parameter int SYNC_STAGES = 2,
    parameter int FRAME_W     = 8
) (
    input logic             clk,
    input logic             reset,
    spi_pwm_cmd_receiver_if.slave bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q, fill_q;
    logic                   sclk_p_q, cs_p_q, armed_q, armed_d;
    logic                   sclk_s, cs_s, mosi_s;
    logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;

    logic [1:0]         state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [FRAME_W-1:0] shreg_q, shreg_d, miso_sh_q, miso_sh_d, echo_q, echo_d, echo_rd;
    logic [2:0]         addr_q, addr_d, val_q, val_d;
    logic               set_q, set_d, ferr_q, ferr_d, pend_q, pend_d, frame_ok;

    assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s   = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    // A cs_n low level seen straight out of reset is not a frame start: fall
    // detection is armed only once a genuine (post-reset) high sample is seen.
    assign armed_d   = armed_q | (fill_q[SYNC_STAGES-1] & cs_s);
    assign sclk_rise = sclk_s & ~sclk_p_q;
    assign sclk_fall = ~sclk_s & sclk_p_q;
    assign cs_fall   = armed_q & cs_p_q & ~cs_s;
    assign cs_rise   = cs_s & ~cs_p_q;

`ifdef PARITY_CHECK_EN
    logic [3:0] errcnt_q, errcnt_d;
    // Accepted frames carry an odd number of ones across bits[7:0].
    assign frame_ok = ^shreg_q;
    assign echo_rd  = {echo_q[7:4], errcnt_q};
`else
    assign frame_ok = 1'b1;
    assign echo_rd  = echo_q;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shreg_d   = shreg_q;
        miso_sh_d = miso_sh_q;
        echo_d    = echo_q;
        addr_d    = addr_q;
        val_d     = val_q;
        pend_d    = pend_q;
        set_d     = 1'b0;
        ferr_d    = 1'b0;
`ifdef PARITY_CHECK_EN
        errcnt_d  = errcnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (cs_fall || pend_q) begin
                    state_d   = S_SHIFT;
                    cnt_d     = 4'd0;
                    shreg_d   = '0;
                    miso_sh_d = echo_rd;
                    pend_d    = 1'b0;
                end
            end
            S_SHIFT: begin
                if (cs_rise) begin
                    state_d = S_DONE;
                end else begin
                    if (sclk_rise) begin
                        shreg_d = {shreg_q[FRAME_W-2:0], mosi_s};
                        if (cnt_q != 4'd9) cnt_d = cnt_q + 4'd1;
                    end
                    if (sclk_fall) miso_sh_d = {miso_sh_q[FRAME_W-2:0], 1'b0};
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                // A new frame starting right now must not be lost.
                pend_d  = cs_fall;
                if (cnt_q == 4'd8 && frame_ok) begin
                    echo_d = shreg_q;
                    if (shreg_q[7]) begin
                        set_d  = 1'b1;
                        addr_d = shreg_q[6:4];
                        val_d  = shreg_q[3:1];
                    end
                end else begin
                    ferr_d = 1'b1;
`ifdef PARITY_CHECK_EN
                    if (errcnt_q != 4'hF) errcnt_d = errcnt_q + 4'd1;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            fill_q      <= '0;
            sclk_p_q    <= 1'b0;
            cs_p_q      <= 1'b1;
            armed_q     <= 1'b0;
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            shreg_q     <= '0;
            miso_sh_q   <= '0;
            echo_q      <= '0;
            addr_q      <= 3'd0;
            val_q       <= 3'd0;
            set_q       <= 1'b0;
            ferr_q      <= 1'b0;
            pend_q      <= 1'b0;
`ifdef PARITY_CHECK_EN
            errcnt_q    <= 4'd0;
`endif
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], bus.spi_sclk};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], bus.spi_cs_n};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.spi_mosi};
            fill_q      <= {fill_q[SYNC_STAGES-2:0], 1'b1};
            sclk_p_q    <= sclk_s;
            cs_p_q      <= cs_s;
            armed_q     <= armed_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shreg_q     <= shreg_d;
            miso_sh_q   <= miso_sh_d;
            echo_q      <= echo_d;
            addr_q      <= addr_d;
            val_q       <= val_d;
            set_q       <= set_d;
            ferr_q      <= ferr_d;
            pend_q      <= pend_d;
`ifdef PARITY_CHECK_EN
            errcnt_q    <= errcnt_d;
`endif
        end
    end

    assign bus.spi_miso  = (state_q == S_SHIFT) & miso_sh_q[FRAME_W-1];
    assign bus.set       = set_q;
    assign bus.addr      = addr_q;
    assign bus.val       = val_q;
    assign bus.frame_err = ferr_q;
endmodule

// File: tb/tb_spi_pwm_cmd_receiver.sv
// Directed bench for spi_pwm_cmd_receiver: SPI host driving frames, checking PWM writes, errors and readback.
module tb_spi_pwm_cmd_receiver;
    localparam int HP = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    spi_pwm_cmd_receiver_if bus();
    spi_pwm_cmd_receiver #(.SYNC_STAGES(2), .FRAME_W(8)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    int checks = 0;
    int errors = 0;
    int set_total = 0, err_total = 0, consec_total = 0;
    logic [2:0] last_addr = 3'd0, last_val = 3'd0;
    logic set_prev = 1'b0;

    always @(negedge clk) begin
        if (bus.set) begin
            set_total++;
            last_addr = bus.addr;
            last_val  = bus.val;
            if (set_prev) consec_total++;
        end
        if (bus.frame_err) err_total++;
        set_prev = bus.set;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wclk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Expected readback of the echo register given the receiver's error count.
    function automatic logic [7:0] rd(input logic [7:0] echo, input logic [3:0] ne);
`ifdef PARITY_CHECK_EN
        return {echo[7:4], ne};
`else
        return echo;
`endif
    endfunction

    task automatic spi_xfer(input logic [15:0] tx, input int n, input bit raise_cs,
                            output logic [15:0] rx);
        rx = '0;
        bus.spi_cs_n = 1'b0;
        wclk(HP);
        for (int i = n - 1; i >= 0; i--) begin
            bus.spi_mosi = tx[i];
            wclk(HP);
            bus.spi_sclk = 1'b1;
            #1 rx = {rx[14:0], bus.spi_miso};
            wclk(HP);
            bus.spi_sclk = 1'b0;
        end
        wclk(HP);
        if (raise_cs) begin
            bus.spi_cs_n = 1'b1;
            wclk(30);
        end
    endtask

    initial begin
        logic [15:0] rx;
        logic [7:0]  t;
        int s0, e0;

        reset = 1'b1;
        bus.spi_cs_n = 1'b1;
        bus.spi_sclk = 1'b0;
        bus.spi_mosi = 1'b0;
        wclk(5);
        reset = 1'b0;
        wclk(5);
        chk("rst_set",  16'(bus.set), 16'd0);
        chk("rst_ferr", 16'(bus.frame_err), 16'd0);
        chk("rst_addr", 16'(bus.addr), 16'd0);
        chk("rst_val",  16'(bus.val), 16'd0);
        chk("rst_miso", 16'(bus.spi_miso), 16'd0);

        // T1: write addr 3 level 5
        s0 = set_total; e0 = err_total;
        spi_xfer(16'h00BA, 8, 1, rx);
        chk("t1_sets", 16'(set_total - s0), 16'd1);
        chk("t1_errs", 16'(err_total - e0), 16'd0);
        chk("t1_addr", 16'(last_addr), 16'd3);
        chk("t1_val",  16'(last_val), 16'd5);
        chk("t1_miso", 16'(rx[7:0]), 16'(rd(8'h00, 4'd0)));

        // T4: read frame returns the T1 frame, no write
        s0 = set_total; e0 = err_total;
        spi_xfer(16'h003B, 8, 1, rx);
        chk("t4_sets", 16'(set_total - s0), 16'd0);
        chk("t4_errs", 16'(err_total - e0), 16'd0);
        chk("t4_miso", 16'(rx[7:0]), 16'(rd(8'hBA, 4'd0)));
        chk("t4_addr", 16'(bus.addr), 16'd3);

        // T2: short frame
        s0 = set_total; e0 = err_total;
        spi_xfer(16'h0015, 5, 1, rx);
        t = rd(8'h3B, 4'd0);
        chk("t2_errs", 16'(err_total - e0), 16'd1);
        chk("t2_sets", 16'(set_total - s0), 16'd0);
        chk("t2_addr", 16'(bus.addr), 16'd3);
        chk("t2_val",  16'(bus.val), 16'd5);
        chk("t2_miso", 16'(rx[4:0]), 16'(t[7:3]));

        // T3: overlong frame, then a good frame
        s0 = set_total; e0 = err_total;
        spi_xfer(16'h03FF, 10, 1, rx);
        chk("t3_errs", 16'(err_total - e0), 16'd1);
        chk("t3_sets", 16'(set_total - s0), 16'd0);
        chk("t3_miso", 16'(rx[9:0]), 16'({rd(8'h3B, 4'd1), 2'b00}));
        s0 = set_total; e0 = err_total;
        spi_xfer(16'h00FE, 8, 1, rx);
        chk("t3b_sets", 16'(set_total - s0), 16'd1);
        chk("t3b_errs", 16'(err_total - e0), 16'd0);
        chk("t3b_addr", 16'(last_addr), 16'd7);
        chk("t3b_val",  16'(last_val), 16'd7);
        chk("t3b_miso", 16'(rx[7:0]), 16'(rd(8'h3B, 4'd2)));
        chk("no_consec", 16'(consec_total), 16'd0);

        // T6: reset at bit 4 with cs_n held low
        s0 = set_total; e0 = err_total;
        spi_xfer(16'h000E, 4, 0, rx);
        reset = 1'b1;
        wclk(3);
        reset = 1'b0;
        spi_xfer(16'h0005, 4, 1, rx);
        chk("t6_sets", 16'(set_total - s0), 16'd0);
        chk("t6_errs", 16'(err_total - e0), 16'd0);
        chk("t6_addr", 16'(bus.addr), 16'd0);
        chk("t6_val",  16'(bus.val), 16'd0);
        s0 = set_total;
        spi_xfer(16'h00E5, 8, 1, rx);
        chk("t6b_sets", 16'(set_total - s0), 16'd1);
        chk("t6b_addr", 16'(last_addr), 16'd6);
        chk("t6b_val",  16'(last_val), 16'd2);
        chk("t6b_miso", 16'(rx[7:0]), 16'(rd(8'h00, 4'd0)));

        // T5: frame 1_001_001_1 from a clean reset
        reset = 1'b1;
        wclk(3);
        reset = 1'b0;
        wclk(10);
        s0 = set_total; e0 = err_total;
        spi_xfer(16'h0093, 8, 1, rx);
`ifdef PARITY_CHECK_EN
        chk("t5_errs", 16'(err_total - e0), 16'd1);
        chk("t5_sets", 16'(set_total - s0), 16'd0);
        spi_xfer(16'h003B, 8, 1, rx);
        chk("t5_miso", 16'(rx[7:0]), 16'h0001);
`else
        chk("t5_errs", 16'(err_total - e0), 16'd0);
        chk("t5_sets", 16'(set_total - s0), 16'd1);
        chk("t5_addr", 16'(last_addr), 16'd1);
        chk("t5_val",  16'(last_val), 16'd1);
        spi_xfer(16'h003B, 8, 1, rx);
        chk("t5_miso", 16'(rx[7:0]), 16'h0093);
`endif
        chk("no_consec_end", 16'(consec_total), 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
